// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types and helpers for the register hazard scoreboard
// Purpose: counter width helper, writeback channel record, default writer depth.
// Ports: none (package).
package hazard_scoreboard_pkg;

  localparam int HS_MAX_INFLIGHT_DEFAULT = 3;
  // Channel records carry the widest datapath; narrower builds zero-extend.
  localparam int HS_XLEN = 64;

  // Bits needed to count 0..max_inflight outstanding writers.
  function automatic int hs_cntw(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

  typedef struct packed {
    logic              valid;
    logic [4:0]        rd;
    logic [HS_XLEN-1:0] data;
  } wb_chan_t;

endpackage

// File: rtl/hazard_query.sv
// rtl/hazard_query.sv - per-read-port hazard decision and bypass mux
// Purpose: decides stall/forward for one source operand from its in-flight count.
// Ports:
//   rs     in  5     source register index
//   cnt    in  CNTW  in-flight writer count for rs (pre-update)
//   chans  in  NWB   writeback channel records, index 0 highest priority
//   stall  out 1     operand must wait
//   fwd    out 1     operand taken from a writeback channel this cycle
//   data   out XLEN  forwarded value (0 when not forwarding)
import hazard_scoreboard_pkg::*;

module hazard_query #(
  parameter int NWB  = 2,
  parameter int XLEN = 64,
  parameter int CNTW = 2
) (
  input  logic [4:0]      rs,
  input  logic [CNTW-1:0] cnt,
  input  wb_chan_t        chans [NWB],
  output logic            stall,
  output logic            fwd,
  output logic [XLEN-1:0] data
);

  logic               hit;
  logic [HS_XLEN-1:0] hit_data;

  // Walk from the lowest-priority channel down so channel 0 wins ties.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = NWB - 1; i >= 0; i--) begin
      if (chans[i].valid && (chans[i].rd == rs)) begin
        hit      = 1'b1;
        hit_data = chans[i].data;
      end
    end
  end

  // Forwarding is only safe with exactly one writer outstanding; with two or
  // more, the retiring value is older than the one the reader must see.
  always_comb begin
    stall = 1'b0;
    fwd   = 1'b0;
    data  = '0;
    if ((rs != 5'd0) && (cnt != '0)) begin
      if ((cnt == CNTW'(1)) && hit) begin
        fwd  = 1'b1;
        data = XLEN'(hit_data);
      end else begin
        stall = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register in-flight writer tracker with bypass select
// Purpose: tracks outstanding writers per register, answers source queries with
//   stall/forward decisions, and gates issue when a register's writer count is full.
// Optional: define HAZARD_PERF_EN to add 64-bit stall/forward cycle counters.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   rs                 in  NRD*5     source register indices
//   rd_stall/rd_fwd    out NRD       per-source stall / forward
//   rd_fwd_data        out NRD*XLEN  forwarded values
//   iss_valid/iss_rd   in            new writer registration
//   iss_ready          out           issue accepted this cycle
//   wb_valid/rd/data   in  NWB       writeback channels (index 0 highest priority)
//   kill_valid/rd      in            squash one in-flight writer
//   err                out           sticky count-underflow flag
//   perf_stall_cycles  out 64        (HAZARD_PERF_EN) cycles with any stall
//   perf_fwd_cycles    out 64        (HAZARD_PERF_EN) cycles with any forward
import hazard_scoreboard_pkg::*;

module hazard_scoreboard #(
  parameter int NREG         = 32,
  parameter int NRD          = 2,
  parameter int NWB          = 2,
  parameter int MAX_INFLIGHT = HS_MAX_INFLIGHT_DEFAULT,
  parameter int XLEN         = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*5-1:0]    rs,
  output logic [NRD-1:0]      rd_stall,
  output logic [NRD-1:0]      rd_fwd,
  output logic [NRD*XLEN-1:0] rd_fwd_data,
  input  logic                iss_valid,
  input  logic [4:0]          iss_rd,
  output logic                iss_ready,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*5-1:0]    wb_rd,
  input  logic [NWB*XLEN-1:0] wb_data,
  input  logic                kill_valid,
  input  logic [4:0]          kill_rd,
  output logic                err
`ifdef HAZARD_PERF_EN
  ,
  output logic [63:0]         perf_stall_cycles,
  output logic [63:0]         perf_fwd_cycles
`endif
);

  localparam int              CNTW  = hs_cntw(MAX_INFLIGHT);
  localparam logic [CNTW-1:0] MAXC  = CNTW'(MAX_INFLIGHT);
  localparam logic [5:0]      NREG6 = 6'(NREG);

  logic [CNTW-1:0] cnt    [NREG];
  logic [CNTW-1:0] nxt    [NREG];
  logic [NREG-1:0] uf;
  logic [CNTW-1:0] rs_cnt [NRD];
  logic [CNTW-1:0] iss_cnt;
  logic            iss_go;
  wb_chan_t        chans  [NWB];

  always_comb begin
    for (int i = 0; i < NWB; i++) begin
      chans[i].valid = wb_valid[i];
      chans[i].rd    = wb_rd[i*5 +: 5];
      chans[i].data  = HS_XLEN'(wb_data[i*XLEN +: XLEN]);
    end
  end

  // Indices beyond NREG are treated as untracked (count 0).
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rs_cnt[p] = '0;
      if ({1'b0, rs[p*5 +: 5]} < NREG6) rs_cnt[p] = cnt[rs[p*5 +: 5]];
    end
  end

  always_comb begin
    iss_cnt = '0;
    if ({1'b0, iss_rd} < NREG6) iss_cnt = cnt[iss_rd];
  end

  assign iss_ready = (iss_rd == 5'd0) || (iss_cnt < MAXC);
  assign iss_go    = iss_valid && iss_ready && (iss_rd != 5'd0);

  // Net change per register; a decrement larger than the count plus this
  // cycle's increment means a retire/kill with no matching writer.
  always_comb begin
    int sum;
    int dec;
    sum = 0;
    dec = 0;
    for (int r = 0; r < NREG; r++) begin
      nxt[r] = '0;
      uf[r]  = 1'b0;
      if (r != 0) begin
        sum = int'(cnt[r]) + ((iss_go && (iss_rd == 5'(r))) ? 1 : 0);
        dec = 0;
        for (int i = 0; i < NWB; i++) begin
          if (wb_valid[i] && (wb_rd[i*5 +: 5] == 5'(r))) dec++;
        end
        if (kill_valid && (kill_rd == 5'(r))) dec++;
        if (dec > sum) begin
          uf[r] = 1'b1;
        end else begin
          nxt[r] = CNTW'(sum - dec);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= nxt[r];
      err <= err | (|uf);
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_query
    hazard_query #(
      .NWB  (NWB),
      .XLEN (XLEN),
      .CNTW (CNTW)
    ) u_query (
      .rs    (rs[g*5 +: 5]),
      .cnt   (rs_cnt[g]),
      .chans (chans),
      .stall (rd_stall[g]),
      .fwd   (rd_fwd[g]),
      .data  (rd_fwd_data[g*XLEN +: XLEN])
    );
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_fwd_cycles   <= '0;
    end else begin
      if (|rd_stall) perf_stall_cycles <= perf_stall_cycles + 64'd1;
      if (|rd_fwd)   perf_fwd_cycles   <= perf_fwd_cycles + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   rs;
  logic [1:0]   rd_stall;
  logic [1:0]   rd_fwd;
  logic [127:0] rd_fwd_data;
  logic         iss_valid;
  logic [4:0]   iss_rd;
  logic         iss_ready;
  logic [1:0]   wb_valid;
  logic [9:0]   wb_rd;
  logic [127:0] wb_data;
  logic         kill_valid;
  logic [4:0]   kill_rd;
  logic         err;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .rs          (rs),
    .rd_stall    (rd_stall),
    .rd_fwd      (rd_fwd),
    .rd_fwd_data (rd_fwd_data),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .iss_ready   (iss_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .kill_valid  (kill_valid),
    .kill_rd     (kill_rd),
    .err         (err)
  );

  typedef struct packed {
    logic [1:0]  stall;
    logic [1:0]  fwd;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        rdy;
    logic        er;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  logic  done_drv = 1'b0;

  task automatic idle();
    iss_valid  = 1'b0;
    iss_rd     = 5'd0;
    rs         = '0;
    wb_valid   = '0;
    wb_rd      = '0;
    wb_data    = '0;
    kill_valid = 1'b0;
    kill_rd    = 5'd0;
  endtask

  task automatic set_wb(input int ch, input logic [4:0] rd, input logic [63:0] d);
    wb_valid[ch]       = 1'b1;
    wb_rd[ch*5 +: 5]   = rd;
    wb_data[ch*64 +: 64] = d;
  endtask

  task automatic expect_out(input string nm, input logic [1:0] st, input logic [1:0] fw,
                            input logic [63:0] d0, input logic [63:0] d1,
                            input logic rdy, input logic er);
    exp_t e;
    e.stall = st;
    e.fwd   = fw;
    e.d0    = d0;
    e.d1    = d1;
    e.rdy   = rdy;
    e.er    = er;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus: each cycle drives inputs after the edge and queues the response.
  initial begin
    reset = 1'b1;
    idle();
    tick();
    for (int k = 0; k < 2; k++) begin
      idle(); iss_valid = 1; iss_rd = 5; rs[4:0] = 5;
      expect_out("reset_hold", 0, 0, 0, 0, 1, 0); tick();
    end
    reset = 1'b0;
    idle(); rs[4:0] = 5;
    expect_out("reset_cnt5", 0, 0, 0, 0, 1, 0); tick();

    idle(); iss_valid = 1; iss_rd = 7; rs[4:0] = 7;
    expect_out("iss7_same_cycle", 0, 0, 0, 0, 1, 0); tick();
    idle(); rs[4:0] = 7;
    expect_out("iss7_stall", 2'b01, 0, 0, 0, 1, 0); tick();
    idle(); rs[4:0] = 7; rs[9:5] = 7; set_wb(1, 7, 64'hDEAD);
    expect_out("iss7_fwd", 0, 2'b11, 64'hDEAD, 64'hDEAD, 1, 0); tick();
    idle(); rs[4:0] = 7;
    expect_out("iss7_clear", 0, 0, 0, 0, 1, 0); tick();

    idle(); iss_valid = 1; iss_rd = 9;
    expect_out("waw_iss1", 0, 0, 0, 0, 1, 0); tick();
    idle(); iss_valid = 1; iss_rd = 9; rs[4:0] = 9;
    expect_out("waw_iss2", 2'b01, 0, 0, 0, 1, 0); tick();
    idle(); rs[4:0] = 9; set_wb(0, 9, 64'd1);
    expect_out("waw_nofwd", 2'b01, 0, 0, 0, 1, 0); tick();
    idle(); rs[4:0] = 9;
    expect_out("waw_cnt1", 2'b01, 0, 0, 0, 1, 0); tick();
    idle(); rs[4:0] = 9; set_wb(0, 9, 64'd5);
    expect_out("waw_fwd", 0, 2'b01, 64'd5, 0, 1, 0); tick();
    idle(); rs[4:0] = 9;
    expect_out("waw_clear", 0, 0, 0, 0, 1, 0); tick();

    for (int k = 0; k < 3; k++) begin
      idle(); iss_valid = 1; iss_rd = 4;
      expect_out("sat_issue", 0, 0, 0, 0, 1, 0); tick();
    end
    idle(); iss_rd = 4; rs[9:5] = 4;
    expect_out("sat_full4", 2'b10, 0, 0, 0, 0, 0); tick();
    idle(); iss_rd = 5;
    expect_out("sat_free5", 0, 0, 0, 0, 1, 0); tick();
    idle(); iss_valid = 1; iss_rd = 4; rs[4:0] = 4; set_wb(0, 4, 64'h44);
    expect_out("sat_iss_wb", 2'b01, 0, 0, 0, 0, 0); tick();
    idle(); iss_valid = 1; iss_rd = 4;
    expect_out("sat_retry", 0, 0, 0, 0, 1, 0); tick();
    idle(); iss_rd = 4;
    expect_out("sat_full_again", 0, 0, 0, 0, 0, 0); tick();
    idle(); rs[4:0] = 4; set_wb(0, 4, 64'h11); set_wb(1, 4, 64'h22);
    expect_out("sat_dual_wb", 2'b01, 0, 0, 0, 1, 0); tick();
    idle(); rs[4:0] = 4; set_wb(0, 4, 64'h44);
    expect_out("sat_last_fwd", 0, 2'b01, 64'h44, 0, 1, 0); tick();
    idle(); iss_rd = 4; rs[4:0] = 4;
    expect_out("sat_drained", 0, 0, 0, 0, 1, 0); tick();

    idle(); iss_valid = 1; iss_rd = 3;
    expect_out("pri_iss", 0, 0, 0, 0, 1, 0); tick();
    idle(); iss_valid = 1; iss_rd = 3; rs[4:0] = 3; rs[9:5] = 3;
    set_wb(0, 3, 64'hA); set_wb(1, 3, 64'hB);
    expect_out("pri_fwd", 0, 2'b11, 64'hA, 64'hA, 1, 0); tick();
    idle(); rs[4:0] = 3;
    expect_out("pri_net_zero", 0, 0, 0, 0, 1, 0); tick();

    idle(); kill_valid = 1; kill_rd = 6;
    expect_out("kill6_cycle", 0, 0, 0, 0, 1, 0); tick();
    idle();
    expect_out("err_set", 0, 0, 0, 0, 1, 1); tick();
    idle();
    expect_out("err_sticky", 0, 0, 0, 0, 1, 1); tick();
    idle(); iss_valid = 1; iss_rd = 8;
    expect_out("kill8_iss", 0, 0, 0, 0, 1, 1); tick();
    idle(); rs[4:0] = 8; kill_valid = 1; kill_rd = 8;
    expect_out("kill8_stall", 2'b01, 0, 0, 0, 1, 1); tick();
    idle(); rs[4:0] = 8;
    expect_out("kill8_clear", 0, 0, 0, 0, 1, 1); tick();

    for (int k = 0; k < 10; k++) begin
      idle(); iss_valid = 1; iss_rd = 0; set_wb(0, 0, 64'hFF);
      expect_out("x0_issue", 0, 0, 0, 0, 1, 1); tick();
    end

    idle(); iss_valid = 1; iss_rd = 10;
    expect_out("rst_iss10", 0, 0, 0, 0, 1, 1); tick();
    idle(); iss_rd = 10; rs[4:0] = 10;
    expect_out("rst_pre", 2'b01, 0, 0, 0, 1, 1); tick();
    idle(); reset = 1'b1; rs[4:0] = 10;
    expect_out("rst_async", 0, 0, 0, 0, 1, 0); tick();
    reset = 1'b0;
    idle(); rs[4:0] = 10;
    expect_out("rst_after", 0, 0, 0, 0, 1, 0); tick();
    idle();
    done_drv = 1'b1;
  end

  int    errors = 0;
  int    checks = 0;
  int    cycles = 0;
  exp_t  cur;
  string cur_nm;

  task automatic check(input string nm, input string fld,
                       input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the queue.
  always @(negedge clk) begin
    cycles++;
    if (exp_q.size() > 0) begin
      cur    = exp_q.pop_front();
      cur_nm = name_q.pop_front();
      check(cur_nm, "rd_stall",  64'(rd_stall),         64'(cur.stall));
      check(cur_nm, "rd_fwd",    64'(rd_fwd),           64'(cur.fwd));
      check(cur_nm, "fwd_data0", rd_fwd_data[63:0],     cur.d0);
      check(cur_nm, "fwd_data1", rd_fwd_data[127:64],   cur.d1);
      check(cur_nm, "iss_ready", 64'(iss_ready),        64'(cur.rdy));
      check(cur_nm, "err",       64'(err),              64'(cur.er));
    end else if (done_drv) begin
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else if (cycles > 5000) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d cycles required=completion", cycles);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

endmodule
